// File: rtl/edf_fifo_read_scheduler.sv
// Earliest-deadline-first read scheduler over four FIFOs feeding one output.
// Picks the non-empty FIFO with the earliest head deadline, reads it, and hands the byte downstream.
module edf_fifo_read_scheduler #(
  parameter int unsigned DW = 8,
  parameter int unsigned TW = 8,
  parameter int unsigned NP = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             enable,
  input  logic [NP-1:0]    fifo_empty,
  input  logic [NP*TW-1:0] fifo_deadline,
  input  logic [NP*DW-1:0] fifo_data,
  output logic [NP-1:0]    fifo_read,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_port,
  output logic             out_late,
  output logic [TW-1:0]    now,
  output logic [15:0]      late_cnt
);

  localparam int unsigned PW = $clog2(NP);
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {IDLE, RD, HOLD} state_t;

  state_t          state, state_d;
  logic [NP-1:0]   fifo_read_d;
  logic            out_valid_d;
  logic [PW-1:0]   out_port_d;
  logic            out_late_d;
  logic [TW-1:0]   now_d;
  logic [CW-1:0]   late_cnt_d;
  logic [PW-1:0]   rr_ptr, rr_ptr_d;

  logic [TW-1:0]   dl [NP];
  logic [NP-1:0]   best;
  logic            any_cand;
  logic [PW-1:0]   win;
  logic            late_win;

  // Wrap-safe ordering: a precedes b when (a-b) lands in the upper half of the tag space.
  function automatic logic earlier(input logic [TW-1:0] a, input logic [TW-1:0] b);
    logic [TW-1:0] d;
    d = TW'(a - b);
    return d[TW-1];
  endfunction

  // Winner: first candidate in round-robin scan order that no other candidate strictly beats.
  always_comb begin
    logic          beaten;
    logic          found;
    logic          fb_found;
    logic [PW-1:0] fb;
    logic [PW-1:0] idx;
    best     = '0;
    found    = 1'b0;
    fb_found = 1'b0;
    fb       = rr_ptr;
    win      = rr_ptr;
    idx      = rr_ptr;
    beaten   = 1'b0;
    for (int unsigned i = 0; i < NP; i++) begin
      dl[i] = fifo_deadline[i*TW +: TW];
    end
    for (int unsigned i = 0; i < NP; i++) begin
      beaten = 1'b0;
      for (int unsigned j = 0; j < NP; j++) begin
        if (!fifo_empty[j] && earlier(dl[j], dl[i])) beaten = 1'b1;
      end
      best[i] = !fifo_empty[i] && !beaten;
    end
    // Fallback covers a non-transitive wrap cycle where every candidate is beaten.
    for (int unsigned k = 1; k <= NP; k++) begin
      idx = rr_ptr + PW'(k);
      if (!found && best[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      if (!fb_found && !fifo_empty[idx]) begin
        fb_found = 1'b1;
        fb       = idx;
      end
    end
    if (!found) win = fb;
    any_cand = |(~fifo_empty);
    late_win = earlier(dl[win], now);
  end

  // Next-state and registered-output logic.
  always_comb begin
    logic start;
    state_d     = state;
    fifo_read_d = '0;
    out_valid_d = out_valid;
    out_port_d  = out_port;
    out_late_d  = out_late;
    now_d       = TW'(now + 1'b1);
    late_cnt_d  = late_cnt;
    rr_ptr_d    = rr_ptr;
    start       = 1'b0;
    case (state)
      IDLE: begin
        out_valid_d = 1'b0;
        if (enable && any_cand) start = 1'b1;
      end
      RD: begin
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_late && late_cnt != {CW{1'b1}}) late_cnt_d = CW'(late_cnt + 1'b1);
          if (enable && any_cand) start = 1'b1;
          else                    state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    if (start) begin
      state_d     = RD;
      out_port_d  = win;
      out_late_d  = late_win;
      rr_ptr_d    = win;
      fifo_read_d = NP'(1) << win;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      fifo_read <= '0;
      out_valid <= 1'b0;
      out_port  <= '0;
      out_late  <= 1'b0;
      now       <= '0;
      late_cnt  <= '0;
      rr_ptr    <= PW'(NP - 1);
    end else begin
      state     <= state_d;
      fifo_read <= fifo_read_d;
      out_valid <= out_valid_d;
      out_port  <= out_port_d;
      out_late  <= out_late_d;
      now       <= now_d;
      late_cnt  <= late_cnt_d;
      rr_ptr    <= rr_ptr_d;
    end
  end

  // The selected FIFO holds its data register steady through HOLD, so a plain mux suffices.
  assign out_data = fifo_data[out_port*DW +: DW];

endmodule

// File: tb/tb_edf_fifo_read_scheduler.sv
// Scoreboard bench for edf_fifo_read_scheduler with behavioural 16-deep FIFOs.
module tb_edf_fifo_read_scheduler;
  localparam int unsigned DW = 8;
  localparam int unsigned TW = 8;
  localparam int unsigned NP = 4;

  logic             CLK = 1'b0;
  logic             RSTn;
  logic             enable;
  logic [NP-1:0]    fifo_empty;
  logic [NP*TW-1:0] fifo_deadline;
  logic [NP*DW-1:0] fifo_data;
  logic [NP-1:0]    fifo_read;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_port;
  logic             out_late;
  logic [TW-1:0]    now;
  logic [15:0]      late_cnt;

  always #5 CLK = ~CLK;

  edf_fifo_read_scheduler #(.DW(DW), .TW(TW), .NP(NP)) dut (
    .CLK(CLK), .RSTn(RSTn), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_deadline(fifo_deadline), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_port(out_port), .out_late(out_late),
    .now(now), .late_cnt(late_cnt)
  );

  // Behavioural FIFOs with a registered read-data port and a bench-side write port.
  logic          fifo_clr;
  logic [NP-1:0] wr_en;
  logic [DW-1:0] wr_data [NP];
  logic [TW-1:0] wr_dl   [NP];
  logic [DW-1:0] f_mem [NP][16];
  logic [TW-1:0] f_dlm [NP][16];
  logic [4:0]    f_cnt [NP];
  logic [3:0]    f_rp  [NP];
  logic [3:0]    f_wp  [NP];
  logic [DW-1:0] f_q   [NP];

  always @(posedge CLK) begin
    for (int i = 0; i < NP; i++) begin
      if (fifo_clr) begin
        f_cnt[i] <= '0;
        f_rp[i]  <= '0;
        f_wp[i]  <= '0;
        f_q[i]   <= '0;
      end else begin
        if (fifo_read[i] && f_cnt[i] != 5'd0) begin
          f_q[i]  <= f_mem[i][f_rp[i]];
          f_rp[i] <= f_rp[i] + 4'd1;
        end
        if (wr_en[i] && f_cnt[i] != 5'd16) begin
          f_mem[i][f_wp[i]] <= wr_data[i];
          f_dlm[i][f_wp[i]] <= wr_dl[i];
          f_wp[i] <= f_wp[i] + 4'd1;
        end
        f_cnt[i] <= f_cnt[i] + 5'(wr_en[i] && f_cnt[i] != 5'd16)
                             - 5'(fifo_read[i] && f_cnt[i] != 5'd0);
      end
    end
  end

  always_comb begin
    fifo_empty    = '0;
    fifo_deadline = '0;
    fifo_data     = '0;
    for (int i = 0; i < NP; i++) begin
      fifo_empty[i]            = (f_cnt[i] == 5'd0);
      fifo_deadline[i*TW +: TW] = (f_cnt[i] != 5'd0) ? f_dlm[i][f_rp[i]] : '0;
      fifo_data[i*DW +: DW]     = f_q[i];
    end
  end

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] port;
    logic       late;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_rd = -1;
  bit   chk_gap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] p, input logic l);
    sb.push_back('{data: d, port: p, late: l});
  endtask

  task automatic stage(input int p, input logic [DW-1:0] d, input logic [TW-1:0] dl);
    wr_en[p]   = 1'b1;
    wr_data[p] = d;
    wr_dl[p]   = dl;
  endtask

  task automatic commit();
    tick();
    wr_en = '0;
  endtask

  // Pops one expectation per accepted byte; also polices read strobes.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RSTn) begin
        if (fifo_read != '0) begin
          chk("rd_onehot", 32'($onehot(fifo_read)), 32'd1);
          chk("rd_nonempty", 32'(fifo_read & fifo_empty), 32'd0);
          if (chk_gap && last_rd >= 0) chk("rd_gap", 32'(cyc - last_rd), 32'd2);
          last_rd = cyc;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte: got data %0h port %0d, expected none", out_data, out_port);
          end else begin
            e = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_port", 32'(out_port), 32'(e.port));
            chk("out_late", 32'(out_late), 32'(e.late));
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending bytes expected 0", name, sb.size());
    end
  endtask

  task automatic wait_read(input string name, input int max);
    int n = 0;
    while (fifo_read == '0 && n < max) begin
      tick();
      n++;
    end
    if (fifo_read == '0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no fifo_read expected a read", name);
    end
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got out_valid 0 expected 1", name);
    end
  endtask

  task automatic do_reset();
    RSTn     = 1'b0;
    fifo_clr = 1'b1;
    enable   = 1'b0;
    out_ready = 1'b0;
    wr_en    = '0;
    sb.delete();
    repeat (2) tick();
    chk("rst_fifo_read", 32'(fifo_read), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_port", 32'(out_port), 32'd0);
    chk("rst_out_late", 32'(out_late), 32'd0);
    chk("rst_now", 32'(now), 32'd0);
    chk("rst_late_cnt", 32'(late_cnt), 32'd0);
    RSTn     = 1'b1;
    fifo_clr = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0; fifo_clr = 1'b1; enable = 1'b0; out_ready = 1'b0; wr_en = '0;
    for (int i = 0; i < NP; i++) begin
      wr_data[i] = '0;
      wr_dl[i]   = '0;
    end
    fork
      monitor();
    join_none

    // Single byte: read pulse, then presentation.
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    stage(0, 8'hA5, 8'h20);
    push_exp(8'hA5, 2'd0, 1'b0);
    commit();
    wait_read("t1_read", 8);
    chk("t1_fifo_read", 32'(fifo_read), 32'h1);
    tick();
    chk("t1_read_one_cycle", 32'(fifo_read), 32'h0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'hA5);
    chk("t1_port", 32'(out_port), 32'd0);
    chk("t1_late", 32'(out_late), 32'd0);
    wait_drain("t1", 10);
    tick();
    chk("t1_late_cnt", 32'(late_cnt), 32'd0);

    // EDF order 1,3,2,0 with reads two cycles apart.
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    last_rd = -1; chk_gap = 1'b1;
    stage(0, 8'hB0, 8'h40);
    stage(1, 8'hB1, 8'h10);
    stage(2, 8'hB2, 8'h30);
    stage(3, 8'hB3, 8'h20);
    push_exp(8'hB1, 2'd1, 1'b0);
    push_exp(8'hB3, 2'd3, 1'b0);
    push_exp(8'hB2, 2'd2, 1'b0);
    push_exp(8'hB0, 2'd0, 1'b0);
    commit();
    wait_drain("t2", 40);
    chk_gap = 1'b0;

    // Wrap compare: 0xF8 precedes 0x08 when now is near 0xED.
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    repeat (8'hEC) tick();
    chk("t3_now", 32'(now), 32'hEC);
    stage(0, 8'hC0, 8'hF8);
    stage(1, 8'hC1, 8'h08);
    push_exp(8'hC0, 2'd0, 1'b0);
    push_exp(8'hC1, 2'd1, 1'b0);
    commit();
    wait_drain("t3", 30);

    // Equal deadlines served round-robin from port 0; enable low blocks reads.
    do_reset();
    out_ready = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < NP; i++) stage(i, 8'(8'h40 + i), 8'h80);
    commit();
    for (int i = 0; i < NP; i++) stage(i, 8'(8'h50 + i), 8'h80);
    commit();
    repeat (4) begin
      chk("t4_en0_noread", 32'(fifo_read), 32'd0);
      chk("t4_en0_novalid", 32'(out_valid), 32'd0);
      tick();
    end
    for (int i = 0; i < NP; i++) push_exp(8'(8'h40 + i), 2'(i), 1'b0);
    for (int i = 0; i < NP; i++) push_exp(8'(8'h50 + i), 2'(i), 1'b0);
    enable = 1'b1;
    wait_drain("t4", 60);

    // Backpressure on a late byte.
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    repeat (16) tick();
    stage(2, 8'h5A, 8'h05);
    push_exp(8'h5A, 2'd2, 1'b1);
    commit();
    wait_valid("t5", 10);
    repeat (5) begin
      chk("t5_hold_valid", 32'(out_valid), 32'd1);
      chk("t5_hold_data", 32'(out_data), 32'h5A);
      chk("t5_hold_port", 32'(out_port), 32'd2);
      chk("t5_hold_late", 32'(out_late), 32'd1);
      chk("t5_hold_noread", 32'(fifo_read), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_late_cnt", 32'(late_cnt), 32'd1);
    repeat (3) begin
      chk("t5_after_noread", 32'(fifo_read), 32'd0);
      tick();
    end
    wait_drain("t5", 2);

    // enable drops during HOLD: byte completes, then idle.
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    stage(0, 8'h61, 8'h40);
    commit();
    stage(0, 8'h62, 8'h40);
    commit();
    push_exp(8'h61, 2'd0, 1'b0);
    wait_valid("t6", 10);
    enable = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (4) begin
      chk("t6_idle_valid", 32'(out_valid), 32'd0);
      chk("t6_idle_noread", 32'(fifo_read), 32'd0);
      tick();
    end
    chk("t6_delivered", 32'(sb.size()), 32'd0);
    push_exp(8'h62, 2'd0, 1'b0);
    out_ready = 1'b1; enable = 1'b1;
    wait_drain("t6", 10);

    // Reset asserted during RD.
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    stage(3, 8'h77, 8'h40);
    commit();
    wait_read("t7_read", 8);
    chk("t7_rd_seen", 32'(fifo_read), 32'h8);
    RSTn = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(out_valid), 32'd0);
    chk("t7_rst_read", 32'(fifo_read), 32'd0);
    chk("t7_rst_now", 32'(now), 32'd0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
